// File: rtl/octal_scan_display_if.sv
// rtl/octal_scan_display_if.sv - digit load bus and display drive lines of the octal scan display
interface octal_scan_display_if #(
  parameter int NUM_DIGITS = 4
);
  logic [3*NUM_DIGITS-1:0] value;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic                    load;
  logic [6:0]              seg;
  logic                    dp;
  logic [NUM_DIGITS-1:0]   an;

  modport master (output value, dp_in, load, input seg, dp, an);
  modport slave  (input value, dp_in, load, output seg, dp, an);
endinterface

// File: rtl/octal_scan_display.sv
// rtl/octal_scan_display.sv - multiplexed octal 7-segment scanner with per-slot anode blanking
// Optional leading-zero suppression is compiled in with LEADING_ZERO_BLANK_EN.
module octal_scan_display #(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  octal_scan_display_if.slave    bus
);

  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYCLES);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

  logic [CNT_W-1:0]        cnt;
  logic [IDX_W-1:0]        idx;
  logic [3*NUM_DIGITS-1:0] value_q;
  logic [NUM_DIGITS-1:0]   dp_q;

  logic [2:0]              digit;
  logic [6:0]              seg_next;
  logic                    dp_next;
  logic [NUM_DIGITS-1:0]   an_next;

  always_comb begin
    digit    = value_q[3*int'(idx) +: 3];
    dp_next  = ~dp_q[idx];
    an_next  = '1;
    if (cnt >= CNT_BLANK) begin
      an_next[idx] = 1'b0;
    end
    case (digit)
      3'd0:    seg_next = 7'h40;
      3'd1:    seg_next = 7'h79;
      3'd2:    seg_next = 7'h24;
      3'd3:    seg_next = 7'h30;
      3'd4:    seg_next = 7'h19;
      3'd5:    seg_next = 7'h12;
      3'd6:    seg_next = 7'h02;
      default: seg_next = 7'h78;
    endcase
`ifdef LEADING_ZERO_BLANK_EN
    // Digit 0 is never suppressed so an all-zero value still reads "0".
    if ((idx != '0) && ((value_q >> (3*int'(idx))) == '0)) begin
      seg_next = 7'h7F;
    end
`else
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      idx     <= '0;
      value_q <= '0;
      dp_q    <= '0;
      bus.seg <= 7'h7F;
      bus.dp  <= 1'b1;
      bus.an  <= '1;
    end else begin
      if (bus.load) begin
        value_q <= bus.value;
        dp_q    <= bus.dp_in;
      end
      if (cnt == CNT_LAST) begin
        cnt <= '0;
        idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
      end
      bus.seg <= seg_next;
      bus.dp  <= dp_next;
      bus.an  <= an_next;
    end
  end

endmodule

// File: tb/tb_octal_scan_display.sv
// tb/tb_octal_scan_display.sv - bench for octal_scan_display (4-digit and 1-digit instances)
module tb_octal_scan_display;

  logic clk = 1'b0;
  logic rst;
  logic rst1;
  always #5 clk = ~clk;

  octal_scan_display_if #(.NUM_DIGITS(4)) bus0();
  octal_scan_display_if #(.NUM_DIGITS(1)) bus1();

  octal_scan_display #(.NUM_DIGITS(4), .REFRESH_DIV(8), .BLANK_CYCLES(2)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0)
  );
  octal_scan_display #(.NUM_DIGITS(1), .REFRESH_DIV(8), .BLANK_CYCLES(2)) dut1 (
    .clk(clk), .rst(rst1), .bus(bus1)
  );

  typedef struct packed {
    logic [11:0]     value;
    logic [3:0]      dp_in;
    logic [3:0][6:0] seg_plain;
    logic [3:0][6:0] seg_lzb;
    logic [3:0]      dp_exp;
  } vec_t;

  typedef struct {
    logic [6:0] seg;
    logic       dp;
    logic [3:0] an;
  } exp_t;

  vec_t       vecs [5];
  logic [6:0] codes [8];
  exp_t       sbq [$];
  int         checks = 0;
  int         errors = 0;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h, expected %h", nm, $time, act, exp);
    end
  endtask

  // Expectation is queued when the cycle is driven and retired once the edge has produced output.
  task automatic expect_next(input logic [6:0] s, input logic d, input logic [3:0] a, input string nm);
    exp_t e;
    e.seg = s; e.dp = d; e.an = a;
    sbq.push_back(e);
    tick();
    if (sbq.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: scoreboard empty", nm);
    end else begin
      e = sbq.pop_front();
      check(nm, {4'h0, bus0.seg, bus0.dp, bus0.an}, {4'h0, e.seg, e.dp, e.an});
    end
  endtask

  // Reset with load held, release, then follow the scan for ncyc cycles.
  task automatic run_scan(input logic [11:0] v, input logic [3:0] dpi, input logic [3:0][6:0] segs,
                          input logic [3:0] dpx, input int ncyc, input string nm);
    int s, c, d;
    logic [3:0] a;
    rst = 1'b1;
    bus0.value = v;
    bus0.dp_in = dpi;
    bus0.load  = 1'b1;
    expect_next(7'h7F, 1'b1, 4'hF, {nm, "_reset_dark"});
    rst = 1'b0;
    for (int n = 1; n <= ncyc; n++) begin
      s = n - 1;
      c = s % 8;
      d = (s / 8) % 4;
      a = (c < 2) ? 4'hF : ~(4'b0001 << d);
      if (n == 1) expect_next(7'h40, 1'b1, a, {nm, "_first"});
      else        expect_next(segs[d], dpx[d], a, nm);
      if (n == 1) bus0.load = 1'b0;
    end
  endtask

  initial begin
    logic [3:0][6:0] segs;
    int s;
    rst  = 1'b1;
    rst1 = 1'b1;
    bus0.value = '0; bus0.dp_in = '0; bus0.load = 1'b0;
    bus1.value = '0; bus1.dp_in = '0; bus1.load = 1'b0;

    codes[0] = 7'h40; codes[1] = 7'h79; codes[2] = 7'h24; codes[3] = 7'h30;
    codes[4] = 7'h19; codes[5] = 7'h12; codes[6] = 7'h02; codes[7] = 7'h78;

    vecs[0] = '{12'o7654, 4'b0010, {7'h78, 7'h02, 7'h12, 7'h19}, {7'h78, 7'h02, 7'h12, 7'h19}, 4'b1101};
    vecs[1] = '{12'o3210, 4'b1001, {7'h30, 7'h24, 7'h79, 7'h40}, {7'h30, 7'h24, 7'h79, 7'h40}, 4'b0110};
    vecs[2] = '{12'o0030, 4'b0000, {7'h40, 7'h40, 7'h30, 7'h40}, {7'h7F, 7'h7F, 7'h30, 7'h40}, 4'b1111};
    vecs[3] = '{12'o0000, 4'b1111, {7'h40, 7'h40, 7'h40, 7'h40}, {7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'b0000};
    vecs[4] = '{12'o0007, 4'b0100, {7'h40, 7'h40, 7'h40, 7'h78}, {7'h7F, 7'h7F, 7'h7F, 7'h78}, 4'b1011};

    tick();
    check("initial_reset", {4'h0, bus0.seg, bus0.dp, bus0.an}, {4'h0, 7'h7F, 1'b1, 4'hF});

    for (int i = 0; i < 5; i++) begin
`ifdef LEADING_ZERO_BLANK_EN
      segs = vecs[i].seg_lzb;
`else
      segs = vecs[i].seg_plain;
`endif
      run_scan(vecs[i].value, vecs[i].dp_in, segs, vecs[i].dp_exp, 40, $sformatf("scan_vec%0d", i));
    end

    for (int dig = 0; dig < 8; dig++) begin
      segs = {codes[dig], codes[dig], codes[dig], codes[dig]};
      run_scan(12'(dig), 4'b0000, segs, 4'hF, 8, $sformatf("code_sweep%0d", dig));
    end

    // Load mid-slot while digit 0 is lit: no slot restart, new code one cycle after capture.
    segs = {7'h40, 7'h40, 7'h40, 7'h30};
    run_scan(12'o0003, 4'b0000, segs, 4'hF, 4, "midload_pre");
    bus0.value = 12'o0005;
    bus0.load  = 1'b1;
    expect_next(7'h30, 1'b1, 4'hE, "midload_capture_edge");
    bus0.load  = 1'b0;
    expect_next(7'h12, 1'b1, 4'hE, "midload_new");
    expect_next(7'h12, 1'b1, 4'hE, "midload_hold");

    // Asynchronous reset between clock edges, then a full blank interval from digit 0.
    #2 rst = 1'b1;
    #1;
    check("async_reset_dark", {4'h0, bus0.seg, bus0.dp, bus0.an}, {4'h0, 7'h7F, 1'b1, 4'hF});
    tick();
    rst = 1'b0;
    expect_next(7'h40, 1'b1, 4'hF, "post_reset_blank0");
    expect_next(7'h40, 1'b1, 4'hF, "post_reset_blank1");
    expect_next(7'h40, 1'b1, 4'hE, "post_reset_first_lit");

    // Single-digit instance: reset together with load must leave value_q at zero.
    bus1.value = 3'o5;
    bus1.dp_in = 1'b1;
    bus1.load  = 1'b1;
    rst1 = 1'b1;
    tick();
    rst1 = 1'b0;
    bus1.load = 1'b0;
    for (int n = 1; n <= 16; n++) begin
      tick();
      s = (n - 1) % 8;
      check($sformatf("single_digit_n%0d", n), {7'h0, bus1.seg, bus1.dp, bus1.an},
            {7'h0, 7'h40, 1'b1, (s < 2) ? 1'b1 : 1'b0});
    end
    bus1.load = 1'b1;
    tick();
    bus1.load = 1'b0;
    check("single_digit_capture_edge", {8'h0, bus1.seg, bus1.dp}, {8'h0, 7'h40, 1'b1});
    tick();
    check("single_digit_new", {8'h0, bus1.seg, bus1.dp}, {8'h0, 7'h12, 1'b0});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/octal_scan_display.md
OCTAL_SCAN_DISPLAY -- requirements
Module: octal_scan_display

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4, number of multiplexed octal digits (legal 1..8).
REQ-002 SHALL have parameter REFRESH_DIV, default 100000, clock cycles per digit slot (legal >= BLANK_CYCLES+2).
REQ-003 SHALL have parameter BLANK_CYCLES, default 16, anti-ghosting cycles at the start of each slot with all anodes off (legal >= 1).
REQ-004 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-005 SHALL have port rst  input  1  reset; asynchronous, active-high.
REQ-006 SHALL have port value  input  3*NUM_DIGITS  octal digits; digit k = value[3k+2:3k]; digit 0 is rightmost.
REQ-007 SHALL have port dp_in  input  NUM_DIGITS  decimal point request per digit, 1 = lit.
REQ-008 SHALL have port load  input  1  capture strobe for value and dp_in.
REQ-009 SHALL have port seg  output  7  segment cathodes, active-low; seg[0]=CA ... seg[6]=CG.
REQ-010 SHALL have port dp  output  1  decimal point cathode, active-low.
REQ-011 SHALL have port an  output  NUM_DIGITS  digit anodes, active-low; an[k] enables digit k.

Function
REQ-012 SHALL capture value into value_q and dp_in into dp_q on a rising edge where load=1; hold them otherwise.
REQ-013 SHALL keep a slot counter cnt counting 0..REFRESH_DIV-1 every cycle; at REFRESH_DIV-1 it wraps to 0.
REQ-014 SHALL keep a digit index idx; when cnt wraps, idx increments, going from NUM_DIGITS-1 to 0.
REQ-015 SHALL register all outputs; the outputs in cycle t+1 reflect cnt, idx, value_q and dp_q in cycle t (one-cycle latency).
REQ-016 SHALL drive an all ones while cnt < BLANK_CYCLES; otherwise an[idx]=0 and every other bit 1.
REQ-017 SHALL drive seg from digit idx of value_q, using active-low seg[6:0] codes: 0=7'h40, 1=7'h79, 2=7'h24, 3=7'h30, 4=7'h19, 5=7'h12, 6=7'h02, 7=7'h78.
REQ-018 SHALL drive dp = ~dp_q[idx].
REQ-019 SHALL, when load occurs mid-slot, show the new digit on the output from the cycle after capture; no slot restart.
REQ-020 SHALL, when NUM_DIGITS=1, hold idx at 0 with cnt still wrapping; blanking per REQ-016 still applies.
REQ-021 SHALL give rst priority over load and counting when they occur together.

Reset
REQ-022 SHALL, while rst=1, force cnt=0, idx=0, value_q=0 and dp_q=0.
REQ-023 SHALL, while rst=1, force seg=7'h7F, dp=1 and an all ones (display dark).
REQ-024 SHALL, after rst deasserts mid-operation, restart scanning from digit 0 with a full blank interval.

Configuration
REQ-025 SHALL treat macro LEADING_ZERO_BLANK_EN as compiling in leading-zero suppression.
REQ-026 With LEADING_ZERO_BLANK_EN defined, SHALL drive seg=7'h7F for each digit k>0 whose digit and all higher digits of value_q are 0.
REQ-027 With LEADING_ZERO_BLANK_EN defined, SHALL still display digit 0 normally, so value 0 shows "0".
REQ-028 With LEADING_ZERO_BLANK_EN defined, SHALL still drive an and dp for suppressed digits per REQ-016/REQ-018.
REQ-029 Without LEADING_ZERO_BLANK_EN, SHALL display all digits unconditionally, including leading zeros.

Verification (NUM_DIGITS=4, REFRESH_DIV=8, BLANK_CYCLES=2 unless stated)
REQ-030 SHALL cover reset: assert rst asynchronously mid-slot -> seg=7'h7F, dp=1 and an=4'b1111 immediately; after release, first an=4'b1110 appears 3 cycles after cnt restarts.
REQ-031 SHALL cover the scan: load value=12'o7654 and dp_in=4'b0010 -> slots show an 1110/1101/1011/0111 with seg 7'h19/7'h12/7'h02/7'h78; dp=0 only in the 1101 slot; each slot has 2 dark cycles then 6 lit cycles, repeating.
REQ-032 SHALL cover all codes: sweep each octal digit 0..7 into digit 0 -> seg matches the REQ-017 table.
REQ-033 SHALL cover mid-slot load: in a lit slot, load digit 0 changing 3 to 5 -> seg changes from 7'h30 to 7'h12 one cycle after the capture edge; an unchanged.
REQ-034 SHALL cover suppression with the macro defined: value=12'o0030 -> digits 3 and 2 give seg 7'h7F, digit 1 gives 7'h30, digit 0 gives 7'h40; value=0 -> only digit 0 shows 7'h40. Without the macro, digits 3 and 2 give 7'h40.
REQ-035 SHALL cover a single digit: NUM_DIGITS=1 -> an toggles 1 (2 cycles) / 0 (6 cycles) each slot; rst together with load leaves value_q=0.
